pwm_cmd_ctrl: RTL and testbench

- Byte-stream command controller that configures and sequences a bank of PWM channels behind the SPI byte interface.
- Decodes a command byte plus two data bytes, MSB first, into per-channel duty and control registers.
- Duty registers are double-buffered. Staged values commit to the PWM datapath only at a period boundary, or immediately if the channel requests it.
- Answers read commands by loading bytes back to the SPI block.

---
 rtl/pwm_cmd_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pwm_cmd_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmd_ctrl.sv
`default_nettype none
//============================================================================
// Module   : pwm_cmd_ctrl
// Brief    : SPI byte-command front end for a bank of double-buffered PWM
//            duty and control registers.
// Revision : 1.0 - initial release
//============================================================================
module pwm_cmd_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [7:0]             data_in,
  input  logic                   data_rdy,
  output logic [7:0]             data_out,
  output logic                   data_latch,
  input  logic                   period_end,
  output logic [NUM_CH*16-1:0]   duty_bus,
  output logic [NUM_CH-1:0]      ch_en,
  output logic                   busy,
  output logic                   err
);

  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t               r_state_q, w_state_d;
  logic [5:0]           r_cmd_q, w_cmd_d;       // {write, channel[2:0], register[1:0]}
  logic [7:0]           r_hi_q, w_hi_d;
  logic [7:0]           r_rd_lo_q, w_rd_lo_d;
  logic [7:0]           r_dout_q, w_dout_d;
  logic                 r_latch_q, w_latch_d;
  logic                 r_err_q, w_err_d;
  logic [c_TMO_W-1:0]   r_tmo_q, w_tmo_d;
  logic [NUM_CH*16-1:0] r_shadow_q, w_shadow_d;
  logic [NUM_CH*16-1:0] r_active_q, w_active_d;
  logic [NUM_CH-1:0]    r_pend_q, w_pend_d;
  logic [NUM_CH-1:0]    r_imm_q, w_imm_d;
  logic [NUM_CH-1:0]    r_en_q, w_en_d;

  logic [2:0]  w_in_ch;
  logic [1:0]  w_in_reg;
  logic        w_rd_oor;
  logic [15:0] w_rd_val;
  logic [2:0]  w_wr_ch;
  logic [1:0]  w_wr_reg;
  logic        w_wr_oor;
  logic [15:0] w_wr_val;

  assign w_in_ch  = data_in[4:2];
  assign w_in_reg = data_in[1:0];
  assign w_rd_oor = (int'(w_in_ch) >= NUM_CH) && (w_in_reg != 2'd3);
  assign w_wr_ch  = r_cmd_q[4:2];
  assign w_wr_reg = r_cmd_q[1:0];
  assign w_wr_oor = (int'(w_wr_ch) >= NUM_CH);
  assign w_wr_val = {r_hi_q, data_in};

  // Read data is taken from the command byte itself so both bytes come from one snapshot.
  always_comb begin
    w_rd_val = 16'h0000;
    if (w_in_reg == 2'd3) begin
      w_rd_val = {15'd0, r_err_q};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(w_in_ch) == i) begin
          case (w_in_reg)
            2'd0:    w_rd_val = r_shadow_q[16*i +: 16];
            2'd1:    w_rd_val = r_active_q[16*i +: 16];
            default: w_rd_val = {14'd0, r_imm_q[i], r_en_q[i]};
          endcase
        end
      end
    end
  end

  always_comb begin
    w_state_d  = r_state_q;
    w_cmd_d    = r_cmd_q;
    w_hi_d     = r_hi_q;
    w_rd_lo_d  = r_rd_lo_q;
    w_dout_d   = r_dout_q;
    w_latch_d  = 1'b0;
    w_err_d    = r_err_q;
    w_tmo_d    = r_tmo_q;
    w_shadow_d = r_shadow_q;
    w_active_d = r_active_q;
    w_pend_d   = r_pend_q;
    w_imm_d    = r_imm_q;
    w_en_d     = r_en_q;

    // Commit first so a same-cycle shadow write re-arms pending afterwards.
    if (period_end) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_pend_q[i]) begin
          w_active_d[16*i +: 16] = r_shadow_q[16*i +: 16];
          w_pend_d[i]            = 1'b0;
        end
      end
    end

    case (r_state_q)
      ST_IDLE: begin
        w_tmo_d = '0;
        if (data_rdy) begin
          w_cmd_d   = {data_in[7], data_in[4:0]};
          w_state_d = ST_HI;
          if (!data_in[7]) begin
            w_dout_d  = w_rd_val[15:8];
            w_rd_lo_d = w_rd_val[7:0];
            w_latch_d = 1'b1;
            if (w_rd_oor) begin
              w_err_d = 1'b1;
            end else if (w_in_reg == 2'd3) begin
              w_err_d = 1'b0;
            end
          end
        end
      end
      ST_HI, ST_LO: begin
        if (data_rdy) begin
          w_tmo_d = '0;
          if (r_state_q == ST_HI) begin
            w_hi_d    = data_in;
            w_state_d = ST_LO;
            if (!r_cmd_q[5]) begin
              w_dout_d  = r_rd_lo_q;
              w_latch_d = 1'b1;
            end
          end else begin
            w_state_d = ST_IDLE;
            if (r_cmd_q[5] && (w_wr_reg != 2'd3)) begin
              if (w_wr_oor) begin
                w_err_d = 1'b1;
              end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (int'(w_wr_ch) == i) begin
                    case (w_wr_reg)
                      2'd0: begin
                        w_shadow_d[16*i +: 16] = w_wr_val;
                        if (r_imm_q[i]) begin
                          w_active_d[16*i +: 16] = w_wr_val;
                          w_pend_d[i]            = 1'b0;
                        end else begin
                          w_pend_d[i] = 1'b1;
                        end
                      end
                      2'd2: begin
                        w_en_d[i]  = data_in[0];
                        w_imm_d[i] = data_in[1];
                      end
                      default: ;
                    endcase
                  end
                end
              end
            end
          end
        end else if (r_tmo_q == c_TMO_LAST) begin
          w_state_d = ST_IDLE;
          w_err_d   = 1'b1;
          w_tmo_d   = '0;
        end else begin
          w_tmo_d = r_tmo_q + c_TMO_W'(1);
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state_q  <= ST_IDLE;
      r_cmd_q    <= '0;
      r_hi_q     <= '0;
      r_rd_lo_q  <= '0;
      r_dout_q   <= '0;
      r_latch_q  <= 1'b0;
      r_err_q    <= 1'b0;
      r_tmo_q    <= '0;
      r_shadow_q <= '0;
      r_active_q <= '0;
      r_pend_q   <= '0;
      r_imm_q    <= '0;
      r_en_q     <= '0;
    end else begin
      r_state_q  <= w_state_d;
      r_cmd_q    <= w_cmd_d;
      r_hi_q     <= w_hi_d;
      r_rd_lo_q  <= w_rd_lo_d;
      r_dout_q   <= w_dout_d;
      r_latch_q  <= w_latch_d;
      r_err_q    <= w_err_d;
      r_tmo_q    <= w_tmo_d;
      r_shadow_q <= w_shadow_d;
      r_active_q <= w_active_d;
      r_pend_q   <= w_pend_d;
      r_imm_q    <= w_imm_d;
      r_en_q     <= w_en_d;
    end
  end

  assign data_out   = r_dout_q;
  assign data_latch = r_latch_q;
  assign duty_bus   = r_active_q;
  assign ch_en      = r_en_q;
  assign busy       = (r_state_q != ST_IDLE);
  assign err        = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_pwm_cmd_ctrl
// Brief    : Scoreboard bench for pwm_cmd_ctrl: transaction-level register
//            model, directed scenarios, then randomized command traffic.
// Revision : 1.0 - initial release
//============================================================================
module tb_pwm_cmd_ctrl;

  localparam int NUM_CH      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                 sys_clk = 1'b0;
  logic                 rst;
  logic [7:0]           data_in;
  logic                 data_rdy;
  logic [7:0]           data_out;
  logic                 data_latch;
  logic                 period_end;
  logic [NUM_CH*16-1:0] duty_bus;
  logic [NUM_CH-1:0]    ch_en;
  logic                 busy;
  logic                 err;

  pwm_cmd_ctrl #(
    .NUM_CH      (NUM_CH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_rdy   (data_rdy),
    .data_out   (data_out),
    .data_latch (data_latch),
    .period_end (period_end),
    .duty_bus   (duty_bus),
    .ch_en      (ch_en),
    .busy       (busy),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Register-level model of the channel bank
  logic [15:0] m_shadow [NUM_CH];
  logic [15:0] m_active [NUM_CH];
  bit          m_pend   [NUM_CH];
  bit          m_imm    [NUM_CH];
  bit          m_en     [NUM_CH];
  bit          m_err;

  typedef struct {
    string                tag;
    logic [NUM_CH*16-1:0] duty;
    logic [NUM_CH-1:0]    en;
    logic                 err;
    logic                 busy;
    bit                   chk_out;
    bit                   end_chk;
  } exp_t;

  logic [7:0] byte_q [$];
  exp_t       st_q   [$];

  function automatic void m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 16'h0000;
      m_active[i] = 16'h0000;
      m_pend[i]   = 1'b0;
      m_imm[i]    = 1'b0;
      m_en[i]     = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic void m_commit();
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_pend[i]) begin
        m_active[i] = m_shadow[i];
        m_pend[i]   = 1'b0;
      end
    end
  endfunction

  function automatic void m_read(input logic [7:0] cmd);
    logic [15:0] v;
    int          ch;
    ch = int'(cmd[4:2]);
    v  = 16'h0000;
    if (cmd[1:0] == 2'd3) begin
      v     = {15'd0, m_err};
      m_err = 1'b0;
    end else if (ch >= NUM_CH) begin
      m_err = 1'b1;
    end else begin
      case (cmd[1:0])
        2'd0:    v = m_shadow[ch];
        2'd1:    v = m_active[ch];
        default: v = {14'd0, m_imm[ch], m_en[ch]};
      endcase
    end
    byte_q.push_back(v[15:8]);
    byte_q.push_back(v[7:0]);
  endfunction

  function automatic void m_write(input logic [7:0] cmd, input logic [15:0] v);
    int ch;
    ch = int'(cmd[4:2]);
    if (cmd[1:0] == 2'd3) return;
    if (ch >= NUM_CH) begin
      m_err = 1'b1;
      return;
    end
    case (cmd[1:0])
      2'd0: begin
        m_shadow[ch] = v;
        if (m_imm[ch]) begin
          m_active[ch] = v;
          m_pend[ch]   = 1'b0;
        end else begin
          m_pend[ch] = 1'b1;
        end
      end
      2'd2: begin
        m_en[ch]  = v[0];
        m_imm[ch] = v[1];
      end
      default: ;
    endcase
  endfunction

  function automatic void expect_state(input string tag, input logic exp_busy, input bit chk_out);
    exp_t e;
    e.tag = tag;
    for (int i = 0; i < NUM_CH; i++) begin
      e.duty[16*i +: 16] = m_active[i];
      e.en[i]            = m_en[i];
    end
    e.err     = m_err;
    e.busy    = exp_busy;
    e.chk_out = chk_out;
    e.end_chk = 1'b0;
    st_q.push_back(e);
  endfunction

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endfunction

  // Monitor: samples on the falling edge, pops expected latch bytes and state snapshots
  logic [7:0] hold_val   = 8'h00;
  bit         prev_latch = 1'b0;

  always @(negedge sys_clk) begin
    exp_t       e;
    logic [7:0] want;
    if (rst !== 1'b1) begin
      hold_val   = 8'h00;
      prev_latch = 1'b0;
    end else if (data_latch === 1'b1) begin
      check("latch_single", 128'(prev_latch), 128'(0));
      if (byte_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL latch_unexpected: got data_out 0x%0h want no latch", data_out);
      end else begin
        want = byte_q.pop_front();
        check("read_byte", 128'(data_out), 128'(want));
        hold_val = want;
      end
      prev_latch = 1'b1;
    end else begin
      check("dout_hold", 128'({data_latch, data_out}), 128'({1'b0, hold_val}));
      prev_latch = 1'b0;
    end

    if (st_q.size() != 0) begin
      e = st_q.pop_front();
      if (e.end_chk) begin
        check("end_queue", 128'(byte_q.size()), 128'(0));
      end else begin
        check({e.tag, ".duty"}, 128'(duty_bus), 128'(e.duty));
        check({e.tag, ".ch_en"}, 128'(ch_en), 128'(e.en));
        check({e.tag, ".err"}, 128'(err), 128'(e.err));
        check({e.tag, ".busy"}, 128'(busy), 128'(e.busy));
        if (e.chk_out) begin
          check({e.tag, ".out"}, 128'({data_latch, data_out}), 128'(0));
        end
      end
    end
  end

  task automatic tick(input logic rdy, input logic [7:0] b, input logic pe);
    data_rdy   = rdy;
    data_in    = b;
    period_end = pe;
    @(posedge sys_clk);
    #1;
    data_rdy   = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic idle(input int n, input bit rand_pe);
    for (int k = 0; k < n; k++) begin
      bit pe;
      pe = rand_pe && ($urandom_range(0, 3) == 0);
      if (pe) m_commit();
      tick(1'b0, 8'h00, pe);
    end
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] lo,
                     input bit pe_lo, input int gap, input bit rand_pe);
    if (!cmd[7]) m_read(cmd);
    tick(1'b1, cmd, 1'b0);
    idle(gap, rand_pe);
    tick(1'b1, hi, 1'b0);
    idle(gap, rand_pe);
    if (pe_lo) m_commit();
    if (cmd[7]) m_write(cmd, {hi, lo});
    tick(1'b1, lo, pe_lo);
  endtask

  initial begin
    exp_t fin;
    rst        = 1'b0;
    data_rdy   = 1'b0;
    data_in    = 8'h00;
    period_end = 1'b0;
    m_reset();
    @(posedge sys_clk);
    #1;

    // Reset held two cycles while bytes keep arriving
    tick(1'b1, 8'h81, 1'b0);
    tick(1'b1, 8'h01, 1'b1);
    expect_state("reset", 1'b0, 1'b1);
    rst = 1'b1;
    idle(2, 1'b0);

    // Staged write waits for period_end
    txn(8'h80, 8'h12, 8'h34, 1'b0, 2, 1'b0);
    expect_state("staged_hold", 1'b0, 1'b0);
    idle(2, 1'b0);
    m_commit();
    tick(1'b0, 8'h00, 1'b1);
    expect_state("staged_commit", 1'b0, 1'b0);
    txn(8'h01, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    idle(2, 1'b0);

    // Immediate mode on channel 1
    txn(8'h86, 8'h00, 8'h03, 1'b0, 1, 1'b0);
    expect_state("ctrl_write", 1'b0, 1'b0);
    txn(8'h84, 8'hAB, 8'hCD, 1'b0, 1, 1'b0);
    expect_state("imm_write", 1'b0, 1'b0);
    idle(2, 1'b0);

    // Write colliding with period_end
    txn(8'h80, 8'h55, 8'h55, 1'b0, 1, 1'b0);
    txn(8'h80, 8'h66, 8'h66, 1'b1, 1, 1'b0);
    expect_state("collide_old", 1'b0, 1'b0);
    idle(1, 1'b0);
    m_commit();
    tick(1'b0, 8'h00, 1'b1);
    expect_state("collide_new", 1'b0, 1'b0);

    // Out-of-range channel, then status read clears err
    txn(8'h9C, 8'hFF, 8'hFF, 1'b0, 1, 1'b0);
    expect_state("oor_write", 1'b0, 1'b0);
    txn(8'h03, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    expect_state("status_clear", 1'b0, 1'b0);
    txn(8'h1D, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    expect_state("oor_read", 1'b0, 1'b0);
    txn(8'h03, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    idle(2, 1'b0);

    // Timeout after the high byte: one cycle short, then expiry
    tick(1'b1, 8'h80, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    idle(TIMEOUT_CYC - 1, 1'b0);
    expect_state("tmo_edge", 1'b1, 1'b0);
    idle(1, 1'b0);
    m_err = 1'b1;
    expect_state("tmo_abort", 1'b0, 1'b0);
    txn(8'h00, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    txn(8'h03, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    idle(2, 1'b0);

    // Byte gaps of exactly TIMEOUT_CYC cycles are still accepted
    tick(1'b1, 8'h80, 1'b0);
    idle(TIMEOUT_CYC - 1, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    idle(TIMEOUT_CYC - 1, 1'b0);
    m_write(8'h80, 16'h2233);
    tick(1'b1, 8'h33, 1'b0);
    expect_state("tmo_gap_ok", 1'b0, 1'b0);
    txn(8'h00, 8'h00, 8'h00, 1'b0, 1, 1'b0);
    idle(2, 1'b0);

    // Reset in the middle of a write
    tick(1'b1, 8'h80, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    idle(2, 1'b0);
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    m_reset();
    expect_state("mid_reset", 1'b0, 1'b1);
    rst = 1'b1;
    idle(2, 1'b0);

    // Randomized command traffic
    for (int n = 0; n < 120; n++) begin
      logic [7:0] cmd;
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cmd[4:2] = 3'($urandom_range(0, NUM_CH - 1));
      txn(cmd, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
          int'($urandom_range(1, 3)), 1'b1);
      expect_state("rand", 1'b0, 1'b0);
      idle(int'($urandom_range(1, 3)), 1'b1);
    end

    idle(3, 1'b0);
    fin         = '{default: '0};
    fin.tag     = "end";
    fin.end_chk = 1'b1;
    st_q.push_back(fin);
    idle(3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
